// File: rtl/instruction_loader_if.sv
// ---------------------------------------------------------------------------
// instruction_loader_if
//   Groups the UART-side input bytes, the pipeline handshake (program end) and
//   the instruction-memory write port of the instruction loader.
//
//   master : the loader's view (consumes rx bytes / prog_end, drives the rest)
//   slave  : the environment's view (uart_rx + pipeline side)
//
//   i_rx_data          received UART byte
//   i_rx_valid         one-cycle pulse, i_rx_data valid
//   i_prog_end         pulse from pipeline, HALT_WORD retired in WB
//   o_we_IF            one-cycle instruction-memory write strobe
//   o_instruction_data assembled word, valid while o_we_IF=1
//   o_halt             1 = pipeline frozen
//   o_word_count       words written in the current load
//   o_state            IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4
//   o_load_error       sticky overflow flag
// ---------------------------------------------------------------------------
interface instruction_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               i_prog_end;
  logic               o_we_IF;
  logic [NB_DATA-1:0] o_instruction_data;
  logic               o_halt;
  logic [NB_ADDR-1:0] o_word_count;
  logic [2:0]         o_state;
  logic               o_load_error;

  modport master (
    input  i_rx_data, i_rx_valid, i_prog_end,
    output o_we_IF, o_instruction_data, o_halt, o_word_count, o_state,
           o_load_error
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_prog_end,
    input  o_we_IF, o_instruction_data, o_halt, o_word_count, o_state,
           o_load_error
  );
endinterface

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//   Sits between uart_rx and the 5-stage MIPS pipeline. In LOAD it assembles
//   little-endian instruction words from UART bytes and writes them into
//   instruction memory; outside LOAD it decodes single-byte commands and
//   drives the pipeline freeze (o_halt) for continuous-run and single-step.
//
//   clk      system clock
//   i_rst_n  asynchronous active-low reset
//   bus      instruction_loader_if.master (rx bytes, prog_end, memory write
//            port, halt, status)
// ---------------------------------------------------------------------------
module instruction_loader #(
  parameter int                NB_DATA   = 32,
  parameter int                NB_BYTE   = 8,
  parameter int                NB_ADDR   = 8,
  parameter int                MEM_WORDS = 256,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  instruction_loader_if.master  bus
);

  localparam int BYTES = NB_DATA / NB_BYTE;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  // One extra bit so the counter can actually hold MEM_WORDS when
  // MEM_WORDS == 2**NB_ADDR.
  localparam int NB_CNT = NB_ADDR + 1;

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_NEXT  = NB_BYTE'(8'h4E);
  localparam logic [NB_BYTE-1:0] CMD_ABORT = NB_BYTE'(8'h52);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BYTES - 1);
  localparam logic [NB_CNT-1:0] CNT_FULL   = NB_CNT'(MEM_WORDS);
  localparam logic [NB_CNT-1:0] CNT_OUTMAX = NB_CNT'({NB_ADDR{1'b1}});

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   byte_idx_reg;
  logic [NB_DATA-1:0] partial_reg;
  logic [NB_DATA-1:0] data_reg;
  logic [NB_CNT-1:0]  count_reg;
  logic               we_reg;
  logic               halt_reg;
  logic               error_reg;

  logic               rx_load;
  logic               byte_store;
  logic [NB_DATA-1:0] assembled_word;

  assign rx_load    = bus.i_rx_valid && (state_reg == LOAD);
  assign byte_store = rx_load && (byte_idx_reg != LAST_IDX);

  // Lower bytes are buffered; the top byte is taken straight from the bus so
  // the word can be written on the very next edge after the last byte.
  always_comb begin
    assembled_word = partial_reg;
    assembled_word[NB_DATA-NB_BYTE +: NB_BYTE] = bus.i_rx_data;
  end

  // Per-byte lanes of the partial word buffer.
  for (genvar gi = 0; gi < BYTES - 1; gi++) begin : g_byte_lane
    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        partial_reg[gi*NB_BYTE +: NB_BYTE] <= '0;
      end else if (byte_store && (byte_idx_reg == IDX_W'(gi))) begin
        partial_reg[gi*NB_BYTE +: NB_BYTE] <= bus.i_rx_data;
      end
    end
  end
  // The top lane is never buffered.
  assign partial_reg[NB_DATA-1 -: NB_BYTE] = '0;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      data_reg     <= '0;
      count_reg    <= '0;
      we_reg       <= 1'b0;
      halt_reg     <= 1'b1;
      error_reg    <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          halt_reg <= 1'b1;
          if (bus.i_rx_valid) begin
            if (bus.i_rx_data == CMD_LOAD) begin
              state_reg    <= LOAD;
              count_reg    <= '0;
              byte_idx_reg <= '0;
              error_reg    <= 1'b0;
            end else if (bus.i_rx_data == CMD_RUN && count_reg != '0) begin
              state_reg <= RUN;
              halt_reg  <= 1'b0;
            end else if (bus.i_rx_data == CMD_STEP && count_reg != '0) begin
              state_reg <= STEP;
            end
          end
        end

        LOAD: begin
          halt_reg <= 1'b1;
          if (rx_load) begin
            if (byte_idx_reg == LAST_IDX) begin
              byte_idx_reg <= '0;
              if (count_reg == CNT_FULL) begin
                // Memory already full: drop the word and abandon the load.
                error_reg <= 1'b1;
                state_reg <= IDLE;
              end else begin
                we_reg    <= 1'b1;
                data_reg  <= assembled_word;
                count_reg <= count_reg + 1'b1;
                if (assembled_word == HALT_WORD) begin
                  state_reg <= IDLE;
                end
              end
            end else begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.i_prog_end) begin
            state_reg <= DONE;
            halt_reg  <= 1'b1;
          end else if (bus.i_rx_valid && bus.i_rx_data == CMD_ABORT) begin
            state_reg <= IDLE;
            halt_reg  <= 1'b1;
          end else begin
            halt_reg <= 1'b0;
          end
        end

        STEP: begin
          // Frozen by default; a 'N' releases the pipeline for one cycle.
          // prog_end takes priority so a coincident 'N' gives no pulse.
          halt_reg <= 1'b1;
          if (bus.i_prog_end) begin
            state_reg <= DONE;
          end else if (bus.i_rx_valid && bus.i_rx_data == CMD_ABORT) begin
            state_reg <= IDLE;
          end else if (bus.i_rx_valid && bus.i_rx_data == CMD_NEXT) begin
            halt_reg <= 1'b0;
          end
        end

        DONE: begin
          halt_reg <= 1'b1;
          if (bus.i_rx_valid) begin
            if (bus.i_rx_data == CMD_LOAD) begin
              state_reg    <= LOAD;
              count_reg    <= '0;
              byte_idx_reg <= '0;
              error_reg    <= 1'b0;
            end else if (bus.i_rx_data == CMD_ABORT) begin
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          halt_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_we_IF            = we_reg;
  assign bus.o_instruction_data = data_reg;
  assign bus.o_halt             = halt_reg;
  assign bus.o_state            = state_reg;
  assign bus.o_load_error       = error_reg;
  // Clamp only matters when MEM_WORDS does not fit in NB_ADDR bits.
  assign bus.o_word_count = (count_reg > CNT_OUTMAX) ? {NB_ADDR{1'b1}}
                                                     : count_reg[NB_ADDR-1:0];

endmodule
